mdu_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the NPC execute stage. It accepts RV M-extension operations from decode alongside the single-cycle ALU. It runs one iterative shift-add or restoring-divide step per cycle, and holds the result until writeback accepts it. While it is busy it raises a stall to the pipeline so no other instruction issues into execute.

---
 rtl/mdu_seq.sv | 157 +++++++++++++++
 tb/tb_mdu_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV M-extension multiply/divide sequencer.
// One shift-add (multiply) or restoring-divide step per cycle on operand
// magnitudes, sign fix on the last step, result held until writeback takes it.
// Optional build macro: MDU_ZERO_SKIP_EN (multiplies by zero finish at once).
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            wreg_o,
  output logic            stall_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;       // |op1|: multiplicand
  logic [XLEN-1:0]   b_q;       // |op2|: divisor
  logic              neg_q;     // final result must be negated
  logic [2*XLEN-1:0] acc_q;     // product, or {remainder, quotient}
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              valid_q;

  // Accept-side decode: operand signedness, magnitudes and special cases
  logic            is_div, sgn1, sgn2, neg1, neg2, res_neg;
  logic            div_zero, div_ovf, mul_zero, special;
  logic [XLEN-1:0] abs1, abs2, special_res;

  always_comb begin
    is_div   = funct3_i[2];
    sgn1     = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
    sgn2     = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
    neg1     = sgn1 & op1_i[XLEN-1];
    neg2     = sgn2 & op2_i[XLEN-1];
    abs1     = neg1 ? -op1_i : op1_i;
    abs2     = neg2 ? -op2_i : op2_i;
    // Remainder follows the dividend; everything else follows the sign product.
    res_neg  = (is_div & funct3_i[1]) ? neg1 : (neg1 ^ neg2);
    div_zero = is_div & (op2_i == '0);
    div_ovf  = is_div & ~funct3_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_i);
`ifdef MDU_ZERO_SKIP_EN
    mul_zero = ~is_div & ((op1_i == '0) | (op2_i == '0));
`else
    mul_zero = 1'b0;
`endif
    special  = div_zero | div_ovf | mul_zero;
    if (mul_zero)      special_res = '0;
    else if (div_zero) special_res = funct3_i[1] ? op1_i : '1;
    else               special_res = funct3_i[1] ? '0 : op1_i;
  end

  // One iteration step plus the sign-fixed result of that step
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_d, div_d, acc_d, prod_fix;
  logic [XLEN-1:0]   q_raw, r_raw, q_fix, r_fix, res_d;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_d    = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, b_q};
    div_d    = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_d    = funct3_q[2] ? div_d : mul_d;
    prod_fix = neg_q ? -acc_d : acc_d;
    q_raw    = acc_d[XLEN-1:0];
    r_raw    = acc_d[2*XLEN-1:XLEN];
    q_fix    = neg_q ? -q_raw : q_raw;
    r_fix    = neg_q ? -r_raw : r_raw;
    case (funct3_q)
      3'b000:         res_d = prod_fix[XLEN-1:0];
      3'b100, 3'b101: res_d = q_fix;
      3'b110, 3'b111: res_d = r_fix;
      default:        res_d = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // Sequencer FSM: flush beats accept and handoff, reset beats everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            funct3_q <= funct3_i;
            rd_q     <= rd_i;
            a_q      <= abs1;
            b_q      <= abs2;
            neg_q    <= res_neg;
            if (special) begin
              result_q <= special_res;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              acc_q   <= is_div ? {{XLEN{1'b0}}, abs1} : {{XLEN{1'b0}}, abs2};
              cnt_q   <= CW'(XLEN - 1);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            result_q <= res_d;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = rst_n & (state_q == IDLE);
  assign stall_o  = rst_n & (state_q != IDLE);
  assign valid_o  = valid_q;
  assign wreg_o   = valid_q;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq (XLEN=64), hand-computed expected values.
module tb_mdu_seq;

  localparam int XLEN = 64;
`ifdef MDU_ZERO_SKIP_EN
  localparam int ZERO_MUL_CYC = 1;
`else
  localparam int ZERO_MUL_CYC = 65;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i, op2_i;
  logic [4:0]      rd_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;
  logic            wreg_o;
  logic            stall_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .op1_i(op1_i), .op2_i(op2_i), .rd_i(rd_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .rd_o(rd_o), .wreg_o(wreg_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency, check result, optionally backpressure, hand off.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_cyc, input int hold);
    int cyc;
    logic [63:0] held;
    chk({tag, ".ready"}, 64'(ready_o), 64'd1);
    funct3_i = f; op1_i = a; op2_i = b; rd_i = rd; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; op1_i = '0; op2_i = '0; rd_i = '0;
    cyc = 1;
    chk({tag, ".stall"}, 64'(stall_o), 64'd1);
    while (!valid_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".result"}, result_o, exp);
    chk({tag, ".rd"}, 64'(rd_o), 64'(rd));
    chk({tag, ".wreg"}, 64'(wreg_o), 64'd1);
    held = result_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_result"}, result_o, held);
      chk({tag, ".hold_stall"}, 64'(stall_o), 64'd1);
      chk({tag, ".hold_valid"}, 64'(valid_o), 64'd1);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({tag, ".handoff_ready"}, 64'(ready_o), 64'd1);
    chk({tag, ".handoff_valid"}, 64'(valid_o), 64'd0);
    $display("op %s f=%0d a=%h b=%h -> %h cyc=%0d", tag, f, a, b, result_o, cyc);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; valid_i = 1'b0; funct3_i = '0; op1_i = '0; op2_i = '0;
    rd_i = '0; flush_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 64'(ready_o), 64'd0);
    chk("rst.valid", 64'(valid_o), 64'd0);
    chk("rst.wreg", 64'(wreg_o), 64'd0);
    chk("rst.stall", 64'(stall_o), 64'd0);
    chk("rst.result", result_o, 64'd0);
    chk("rst.rd", 64'(rd_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7x-3",  3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
           64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("mulh_m1m1", 3'b001, '1, '1, 5'd6, 64'd0, 65, 0);
    run_op("mulhu_m1m1", 3'b011, '1, '1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("mulhsu_m1x2", 3'b010, '1, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu_100_7", 3'b101, 64'd100, 64'd7, 5'd9, 64'd14, 65, 0);
    run_op("remu_100_7", 3'b111, 64'd100, 64'd7, 5'd10, 64'd2, 65, 0);
    run_op("div_-100_7", 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd11,
           64'hFFFF_FFFF_FFFF_FFF2, 65, 0);
    run_op("rem_-100_7", 3'b110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd12,
           64'hFFFF_FFFF_FFFF_FFFE, 65, 3);
    run_op("div_100_0", 3'b100, 64'd100, 64'd0, 5'd13, '1, 1, 0);
    run_op("rem_100_0", 3'b110, 64'd100, 64'd0, 5'd14, 64'd100, 1, 2);
    run_op("div_ovf", 3'b100, 64'h8000_0000_0000_0000, '1, 5'd15,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", 3'b110, 64'h8000_0000_0000_0000, '1, 5'd16, 64'd0, 1, 0);
    run_op("mul_zero", 3'b000, 64'd0, 64'd12345, 5'd17, 64'd0, ZERO_MUL_CYC, 0);

    // Flush in BUSY cycle 10: back to IDLE, no result ever appears
    funct3_i = 3'b000; op1_i = 64'd123; op2_i = 64'd456; rd_i = 5'd20; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("flush.busy_stall", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush.ready", 64'(ready_o), 64'd1);
    chk("flush.stall", 64'(stall_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (valid_o) seen++;
      @(posedge clk); #1;
    end
    chk("flush.no_valid", 64'(seen), 64'd0);
    $display("op flush MUL 123x456 at busy cycle 10, valid cycles seen=%0d", seen);

    run_op("mul_3x5", 3'b000, 64'd3, 64'd5, 5'd21, 64'd15, 65, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
